// File: rtl/idli_pctl_m.sv
// idli predicate controller: evaluates each issued instruction's guard through
// PRF read port P and holds execute for len+1 cycles. It also funnels compare and
// debug predicate writes through a one-entry write stage onto PRF port Q, and
// stalls issue while a predicate it needs is still being written.
module idli_pctl_m #(
   parameter int LEN_W = 4
) (
   input  logic             i_pctl_gck,
   input  logic             i_pctl_rst_n,
   // issue
   input  logic             i_pctl_issue_vld,
   output logic             o_pctl_issue_rdy,
   input  logic [1:0]       i_pctl_issue_p,
   input  logic             i_pctl_issue_inv,
   input  logic [LEN_W-1:0] i_pctl_issue_len,
   // PRF read port P
   output logic [1:0]       o_pctl_prf_p,
   input  logic             i_pctl_prf_p_data,
   // execute status
   output logic             o_pctl_exec_vld,
   output logic             o_pctl_exec_en,
   output logic             o_pctl_exec_last,
   // compare unit write request
   input  logic             i_pctl_cmp_vld,
   input  logic [1:0]       i_pctl_cmp_p,
   input  logic             i_pctl_cmp_data,
   output logic             o_pctl_cmp_rdy,
   // debug write request
   input  logic             i_pctl_dbg_vld,
   input  logic [1:0]       i_pctl_dbg_p,
   input  logic             i_pctl_dbg_data,
   output logic             o_pctl_dbg_rdy,
   // PRF write port Q
   output logic [1:0]       o_pctl_prf_q,
   output logic             o_pctl_prf_q_wr_en,
   output logic             o_pctl_prf_q_data
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   state_e           state_q;
   logic [LEN_W-1:0] count_q;
   logic             exec_en_q;

   logic             wb_vld_q, wb_vld_d;
   logic [1:0]       wb_p_q, wb_p_d;
   logic             wb_data_q, wb_data_d;

   logic             exec_last;
   logic             hazard;
   logic             issue_acc;

   // P3 is hard-wired to 1 in the PRF, so it never needs to wait for a write.
   // The incoming write is older than the instruction being issued, so both the
   // staged write and the one being accepted right now block a matching guard.
   always_comb begin
      hazard = 1'b0;
      if (i_pctl_issue_p != 2'd3) begin
         if (wb_vld_q && (wb_p_q == i_pctl_issue_p))
            hazard = 1'b1;
         if (wb_vld_d && (wb_p_d == i_pctl_issue_p))
            hazard = 1'b1;
      end
   end

   // Compare always wins the write stage; debug only gets in when compare is quiet.
   always_comb begin
      wb_vld_d  = 1'b0;
      wb_p_d    = 2'd0;
      wb_data_d = 1'b0;
      if (i_pctl_cmp_vld) begin
         wb_vld_d  = 1'b1;
         wb_p_d    = i_pctl_cmp_p;
         wb_data_d = i_pctl_cmp_data;
      end else if (i_pctl_dbg_vld) begin
         wb_vld_d  = 1'b1;
         wb_p_d    = i_pctl_dbg_p;
         wb_data_d = i_pctl_dbg_data;
      end
   end

   assign exec_last = (state_q == ST_EXEC) && (count_q == '0);
   assign o_pctl_issue_rdy = ((state_q == ST_IDLE) || exec_last) && !hazard;
   assign issue_acc = i_pctl_issue_vld && o_pctl_issue_rdy;

   // Issue/execute FSM; a new instruction may be accepted on the last execute
   // cycle of the previous one so back-to-back instructions have no bubble.
   always_ff @(posedge i_pctl_gck or negedge i_pctl_rst_n) begin
      if (!i_pctl_rst_n) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         exec_en_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (issue_acc) begin
                  state_q   <= ST_EXEC;
                  count_q   <= i_pctl_issue_len;
                  exec_en_q <= i_pctl_prf_p_data ^ i_pctl_issue_inv;
               end
            end
            ST_EXEC: begin
               if (count_q != '0) begin
                  count_q <= count_q - 1'b1;
               end else if (issue_acc) begin
                  count_q   <= i_pctl_issue_len;
                  exec_en_q <= i_pctl_prf_p_data ^ i_pctl_issue_inv;
               end else begin
                  state_q   <= ST_IDLE;
                  exec_en_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               exec_en_q <= 1'b0;
            end
         endcase
      end
   end

   // One-entry write stage: reloads every cycle, so it drains without backpressure.
   always_ff @(posedge i_pctl_gck or negedge i_pctl_rst_n) begin
      if (!i_pctl_rst_n) begin
         wb_vld_q  <= 1'b0;
         wb_p_q    <= 2'd0;
         wb_data_q <= 1'b0;
      end else begin
         wb_vld_q  <= wb_vld_d;
         wb_p_q    <= wb_p_d;
         wb_data_q <= wb_data_d;
      end
   end

   assign o_pctl_prf_p       = i_pctl_issue_p;
   assign o_pctl_exec_vld    = (state_q == ST_EXEC);
   assign o_pctl_exec_en     = exec_en_q;
   assign o_pctl_exec_last   = exec_last;
   assign o_pctl_cmp_rdy     = 1'b1;
   assign o_pctl_dbg_rdy     = !i_pctl_cmp_vld;
   assign o_pctl_prf_q       = wb_p_q;
   // Writes aimed at the constant P3 are consumed here and never reach the PRF.
   assign o_pctl_prf_q_wr_en = wb_vld_q && (wb_p_q != 2'd3);
   assign o_pctl_prf_q_data  = wb_data_q;

endmodule

// File: tb/tb_idli_pctl_m.sv
// Directed bench for idli_pctl_m with a tiny PRF model attached to ports P and Q.
module tb_idli_pctl_m;

   localparam int LEN_W = 4;

   logic             clk;
   logic             rst_n;
   logic             issue_vld;
   logic             issue_rdy;
   logic [1:0]       issue_p;
   logic             issue_inv;
   logic [LEN_W-1:0] issue_len;
   logic [1:0]       prf_p;
   logic             prf_p_data;
   logic             exec_vld;
   logic             exec_en;
   logic             exec_last;
   logic             cmp_vld;
   logic [1:0]       cmp_p;
   logic             cmp_data;
   logic             cmp_rdy;
   logic             dbg_vld;
   logic [1:0]       dbg_p;
   logic             dbg_data;
   logic             dbg_rdy;
   logic [1:0]       prf_q;
   logic             prf_q_wr_en;
   logic             prf_q_data;

   int n_cmp = 0;
   int n_err = 0;

   logic prf [0:3];

   idli_pctl_m #(.LEN_W(LEN_W)) dut (
      .i_pctl_gck         (clk),
      .i_pctl_rst_n       (rst_n),
      .i_pctl_issue_vld   (issue_vld),
      .o_pctl_issue_rdy   (issue_rdy),
      .i_pctl_issue_p     (issue_p),
      .i_pctl_issue_inv   (issue_inv),
      .i_pctl_issue_len   (issue_len),
      .o_pctl_prf_p       (prf_p),
      .i_pctl_prf_p_data  (prf_p_data),
      .o_pctl_exec_vld    (exec_vld),
      .o_pctl_exec_en     (exec_en),
      .o_pctl_exec_last   (exec_last),
      .i_pctl_cmp_vld     (cmp_vld),
      .i_pctl_cmp_p       (cmp_p),
      .i_pctl_cmp_data    (cmp_data),
      .o_pctl_cmp_rdy     (cmp_rdy),
      .i_pctl_dbg_vld     (dbg_vld),
      .i_pctl_dbg_p       (dbg_p),
      .i_pctl_dbg_data    (dbg_data),
      .o_pctl_dbg_rdy     (dbg_rdy),
      .o_pctl_prf_q       (prf_q),
      .o_pctl_prf_q_wr_en (prf_q_wr_en),
      .o_pctl_prf_q_data  (prf_q_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PRF model: P3 reads constant 1, P0-P2 updated from port Q.
   assign prf_p_data = (prf_p == 2'd3) ? 1'b1 : prf[prf_p];
   always @(posedge clk) begin
      if (prf_q_wr_en)
         prf[prf_q] <= prf_q_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", tag, got, $time);
      end
   endtask

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // let combinational outputs settle, still well clear of either edge
   task automatic settle();
      #2;
   endtask

   // compare write to P1 colliding with an issue guarded by P1
   task automatic haz_run(input logic inv, input logic exp_en);
      cmp_vld = 1'b1; cmp_p = 2'd1; cmp_data = 1'b0;
      issue_vld = 1'b1; issue_p = 2'd1; issue_inv = inv; issue_len = 4'd0;
      settle();
      chk("haz_rdy_c0", issue_rdy, 0);
      chk("haz_dbg_rdy", dbg_rdy, 0);
      cyc();
      cmp_vld = 1'b0;
      settle();
      chk("haz_rdy_c1", issue_rdy, 0);
      chk("haz_wr_en", prf_q_wr_en, 1);
      cyc();
      settle();
      chk("haz_rdy_c2", issue_rdy, 1);
      cyc();
      issue_vld = 1'b0;
      settle();
      chk("haz_exec_vld", exec_vld, 1);
      chk("haz_exec_en", exec_en, exp_en);
      chk("haz_exec_last", exec_last, 1);
      cyc();
   endtask

   initial begin
      int nvld;
      for (int i = 0; i < 4; i++) prf[i] = 1'b0;
      rst_n = 1'b0;
      issue_vld = 1'b0; issue_p = 2'd0; issue_inv = 1'b0; issue_len = '0;
      cmp_vld = 1'b0; cmp_p = 2'd0; cmp_data = 1'b0;
      dbg_vld = 1'b0; dbg_p = 2'd0; dbg_data = 1'b0;

      // reset state
      cyc(); cyc();
      settle();
      chk("rst_exec_vld", exec_vld, 0);
      chk("rst_exec_last", exec_last, 0);
      chk("rst_exec_en", exec_en, 0);
      chk("rst_wr_en", prf_q_wr_en, 0);
      chk("rst_prf_q", prf_q, 0);
      chk("rst_prf_q_data", prf_q_data, 0);
      chk("rst_cmp_rdy", cmp_rdy, 1);
      cyc();
      rst_n = 1'b1;
      cyc();

      // issue p=3 inv=0 len=3: four execute cycles, last only on the fourth
      issue_vld = 1'b1; issue_p = 2'd3; issue_inv = 1'b0; issue_len = 4'd3;
      settle();
      chk("t1_rdy", issue_rdy, 1);
      chk("t1_prf_p", prf_p, 3);
      cyc();
      issue_vld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk($sformatf("t1_vld_%0d", i), exec_vld, 1);
         chk($sformatf("t1_en_%0d", i), exec_en, 1);
         chk($sformatf("t1_last_%0d", i), exec_last, (i == 3) ? 1 : 0);
         cyc();
      end
      settle();
      chk("t1_idle_vld", exec_vld, 0);
      chk("t1_idle_en", exec_en, 0);

      // preset P1=1 through debug so the hazard case observes a real change
      dbg_vld = 1'b1; dbg_p = 2'd1; dbg_data = 1'b1;
      cyc();
      dbg_vld = 1'b0;
      settle();
      chk("pre_wr_en", prf_q_wr_en, 1);
      chk("pre_prf_q", prf_q, 1);
      chk("pre_q_data", prf_q_data, 1);
      cyc();

      // RAW hazard on P1, guard sense plain then inverted
      haz_run(1'b0, 1'b0);
      haz_run(1'b1, 1'b1);

      // compare and debug collide: compare first, debug one cycle later
      cmp_vld = 1'b1; cmp_p = 2'd0; cmp_data = 1'b1;
      dbg_vld = 1'b1; dbg_p = 2'd2; dbg_data = 1'b1;
      settle();
      chk("arb_dbg_rdy0", dbg_rdy, 0);
      chk("arb_cmp_rdy", cmp_rdy, 1);
      cyc();
      cmp_vld = 1'b0;
      settle();
      chk("arb_wr_en0", prf_q_wr_en, 1);
      chk("arb_q0", prf_q, 0);
      chk("arb_data0", prf_q_data, 1);
      chk("arb_dbg_rdy1", dbg_rdy, 1);
      cyc();
      dbg_vld = 1'b0;
      settle();
      chk("arb_wr_en1", prf_q_wr_en, 1);
      chk("arb_q1", prf_q, 2);
      chk("arb_data1", prf_q_data, 1);
      cyc();
      settle();
      chk("arb_wr_en2", prf_q_wr_en, 0);
      // P2 now 1: guard reads true with no stall
      issue_vld = 1'b1; issue_p = 2'd2; issue_inv = 1'b0; issue_len = 4'd0;
      settle();
      chk("arb_p2_rdy", issue_rdy, 1);
      cyc();
      issue_vld = 1'b0;
      settle();
      chk("arb_p2_en", exec_en, 1);
      cyc();

      // back-to-back len=0 issues, second inverted
      issue_vld = 1'b1; issue_p = 2'd3; issue_inv = 1'b0; issue_len = 4'd0;
      settle();
      chk("b2b_rdy0", issue_rdy, 1);
      cyc();
      issue_inv = 1'b1;
      settle();
      chk("b2b_vld0", exec_vld, 1);
      chk("b2b_last0", exec_last, 1);
      chk("b2b_en0", exec_en, 1);
      chk("b2b_rdy1", issue_rdy, 1);
      cyc();
      issue_vld = 1'b0;
      settle();
      chk("b2b_vld1", exec_vld, 1);
      chk("b2b_last1", exec_last, 1);
      chk("b2b_en1", exec_en, 0);
      cyc();
      settle();
      chk("b2b_idle", exec_vld, 0);

      // debug write to P3 is dropped; issue on P3 never stalls
      dbg_vld = 1'b1; dbg_p = 2'd3; dbg_data = 1'b0;
      cyc();
      dbg_vld = 1'b0;
      issue_vld = 1'b1; issue_p = 2'd3; issue_inv = 1'b0; issue_len = 4'd1;
      settle();
      chk("p3_wr_en", prf_q_wr_en, 0);
      chk("p3_prf_q", prf_q, 3);
      chk("p3_rdy", issue_rdy, 1);
      cyc();
      issue_vld = 1'b0;
      settle();
      chk("p3_en", exec_en, 1);
      chk("p3_last0", exec_last, 0);
      cyc();
      settle();
      chk("p3_last1", exec_last, 1);
      cyc();

      // maximum length: sixteen execute cycles, counted with a bound
      issue_vld = 1'b1; issue_p = 2'd3; issue_inv = 1'b0; issue_len = 4'd15;
      cyc();
      issue_vld = 1'b0;
      nvld = 0;
      for (int i = 0; i < 40; i++) begin
         settle();
         if (exec_vld) nvld++;
         cyc();
      end
      chk("max_len_cycles", nvld, 16);

      // reset mid-execute with a compare write pending
      issue_vld = 1'b1; issue_p = 2'd3; issue_inv = 1'b0; issue_len = 4'd5;
      cyc();
      issue_vld = 1'b0;
      cmp_vld = 1'b1; cmp_p = 2'd0; cmp_data = 1'b0;
      cyc();
      cmp_vld = 1'b0;
      settle();
      chk("rm_pre_vld", exec_vld, 1);
      chk("rm_pre_wr_en", prf_q_wr_en, 1);
      rst_n = 1'b0;
      #1;
      chk("rm_vld", exec_vld, 0);
      chk("rm_wr_en", prf_q_wr_en, 0);
      chk("rm_en", exec_en, 0);
      chk("rm_prf_q", prf_q, 0);
      cyc();
      rst_n = 1'b1;
      settle();
      chk("rm_after_vld", exec_vld, 0);
      chk("rm_after_rdy", issue_rdy, 1);
      cyc();
      settle();
      chk("rm_after2_vld", exec_vld, 0);
      chk("rm_p0_kept", prf[0], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
